// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared clock/reset descriptor and memory response-entry type.
// Revision : 1.0
// ============================================================================
package mem_pkg;

    typedef struct packed {
        logic reset_active_low;
    } std_clock_info_t;

    function automatic logic std_is_reset_active(input std_clock_info_t info, input logic rst);
        return info.reset_active_low ? ~rst : rst;
    endfunction

    // Widest supported fields; narrower users zero-extend into the entry.
    localparam int unsigned c_max_data_width = 512;
    localparam int unsigned c_max_addr_width = 64;
    localparam int unsigned c_max_id_width   = 32;

    typedef logic [c_max_data_width-1:0] mem_data_t;
    typedef logic [c_max_addr_width-1:0] mem_addr_t;
    typedef logic [c_max_id_width-1:0]   mem_id_t;

    typedef struct packed {
        logic      valid;
        mem_id_t   id;
        mem_addr_t addr;
        mem_data_t data;
    } mem_resp_t;

endpackage
`default_nettype wire

// File: rtl/mem_intf.sv
`default_nettype none
// ============================================================================
// Module   : mem_intf
// Brief    : Valid/ready memory request/response stream.
// Revision : 1.0
// ============================================================================
interface mem_intf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 1
) ();
    logic                    valid;
    logic                    ready;
    logic                    read_enable;
    logic [DATA_WIDTH/8-1:0] write_enable;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data;
    logic [ID_WIDTH-1:0]     id;

    modport in  (input  valid, read_enable, write_enable, addr, data, id, output ready);
    modport out (output valid, read_enable, write_enable, addr, data, id, input  ready);
endinterface
`default_nettype wire

// File: rtl/mem_ram_bank.sv
`default_nettype none
// ============================================================================
// Module   : mem_ram_bank
// Brief    : Single-port byte-enable RAM, registered read-before-write.
// Revision : 1.0
// ============================================================================
module mem_ram_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int WORD_BITS  = 10
) (
    input  logic                    clk,
    input  logic                    i_en,
    input  logic [DATA_WIDTH/8-1:0] i_we,
    input  logic [WORD_BITS-1:0]    i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);
    localparam int c_bytes = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [0:(2**WORD_BITS)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // The read port returns the word as it was before this cycle's write.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata <= r_mem[i_addr];
            for (int b = 0; b < c_bytes; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_ram_responder
// Brief    : RAM behind a valid/ready request stream with an in-order
//            response stream (up to two responses in flight).
//            Define MEM_RAM_RESPONDER_WRITE_ACK_EN to acknowledge write-only
//            requests with the post-write word.
// Revision : 1.0
// ============================================================================
module mem_ram_responder
    import mem_pkg::*;
#(
    parameter std_clock_info_t CLOCK_INFO = 'b0,
    parameter int              DATA_WIDTH = 32,
    parameter int              ADDR_WIDTH = 32,
    parameter int              WORD_BITS  = 10,
    parameter int              ID_WIDTH   = 1
) (
    input  logic   clk,
    input  logic   rst,
    mem_intf.in    mem_in,
    mem_intf.out   mem_out
);
    logic                  w_rst;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_wants_resp;
    logic                  w_resp_accept;
    logic                  w_out_valid;
    logic                  w_out_fire;
    logic                  w_s1_stall;
    logic [1:0]            r_outstanding;
    logic                  r_s1_valid;
    logic [ID_WIDTH-1:0]   r_s1_id;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic [DATA_WIDTH-1:0] w_ram_rdata;
    logic [DATA_WIDTH-1:0] w_s1_data;
    mem_resp_t             w_s1_entry;
    mem_resp_t             r_hold;
    logic                  w_unused_bits;

    assign w_rst         = std_is_reset_active(CLOCK_INFO, rst);
    assign w_in_ready    = !w_rst && (r_outstanding < 2'd2);
    assign w_accept      = mem_in.valid && w_in_ready;
    assign w_resp_accept = w_accept && w_wants_resp;

    mem_ram_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_BITS  (WORD_BITS)
    ) u_bank (
        .clk     (clk),
        .i_en    (w_accept),
        .i_we    (mem_in.write_enable),
        .i_addr  (mem_in.addr[WORD_BITS-1:0]),
        .i_wdata (mem_in.data),
        .o_rdata (w_ram_rdata)
    );

`ifdef MEM_RAM_RESPONDER_WRITE_ACK_EN
    logic [DATA_WIDTH/8-1:0] r_s1_we;
    logic [DATA_WIDTH-1:0]   r_s1_wdata;
    logic                    r_s1_post;

    assign w_wants_resp = mem_in.read_enable || (|mem_in.write_enable);

    // Write acks report the word after the write: re-merge the stored bytes.
    always_comb begin
        w_s1_data = w_ram_rdata;
        if (r_s1_post) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (r_s1_we[b]) begin
                    w_s1_data[b*8 +: 8] = r_s1_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!w_s1_stall && w_resp_accept) begin
            r_s1_we    <= mem_in.write_enable;
            r_s1_wdata <= mem_in.data;
            r_s1_post  <= !mem_in.read_enable;
        end
    end
`else
    assign w_wants_resp = mem_in.read_enable;
    assign w_s1_data    = w_ram_rdata;
`endif

    always_comb begin
        w_s1_entry       = '0;
        w_s1_entry.valid = r_s1_valid;
        w_s1_entry.id    = mem_id_t'(r_s1_id);
        w_s1_entry.addr  = mem_addr_t'(r_s1_addr);
        w_s1_entry.data  = mem_data_t'(w_s1_data);
    end

    assign w_out_valid = !w_rst && (r_hold.valid || r_s1_valid);
    assign w_out_fire  = w_out_valid && mem_out.ready;
    // Stage 1 can only wait behind the holding entry; the RAM output is
    // frozen then because two responses in flight block new accepts.
    assign w_s1_stall  = r_s1_valid && r_hold.valid && !w_out_fire;

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_outstanding <= 2'd0;
            r_s1_valid    <= 1'b0;
            r_hold        <= '0;
        end else begin
            r_outstanding <= r_outstanding + {1'b0, w_resp_accept} - {1'b0, w_out_fire};

            if (!r_hold.valid || w_out_fire) begin
                if (r_s1_valid && (r_hold.valid || !w_out_fire)) begin
                    r_hold <= w_s1_entry;
                end else begin
                    r_hold.valid <= 1'b0;
                end
            end

            if (!w_s1_stall) begin
                r_s1_valid <= w_resp_accept;
                if (w_resp_accept) begin
                    r_s1_id   <= mem_in.id;
                    r_s1_addr <= mem_in.addr;
                end
            end
        end
    end

    assign mem_in.ready         = w_in_ready;
    assign mem_out.valid        = w_out_valid;
    assign mem_out.read_enable  = 1'b1;
    assign mem_out.write_enable = '0;
    assign mem_out.data         = r_hold.valid ? r_hold.data[DATA_WIDTH-1:0] : w_s1_data;
    assign mem_out.id           = r_hold.valid ? r_hold.id[ID_WIDTH-1:0]     : r_s1_id;
    assign mem_out.addr         = r_hold.valid ? r_hold.addr[ADDR_WIDTH-1:0] : r_s1_addr;

    assign w_unused_bits = ^{r_hold.data, r_hold.id, r_hold.addr, mem_in.addr};

endmodule
`default_nettype wire

// File: doc/mem_ram_responder.md
MEM_RAM_RESPONDER -- requirements
Module: mem_ram_responder

Interface
REQ-001 SHALL have parameter CLOCK_INFO, default 'b0, std_clock_info_t; reset is synchronous, active-high, tested via std_is_reset_active(CLOCK_INFO, rst).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width in bits (multiple of 8).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, mem_intf address width; RAM is word-indexed by addr[WORD_BITS-1:0].
REQ-004 SHALL have parameter WORD_BITS, default 10, RAM depth 2**WORD_BITS words.
REQ-005 SHALL have parameter ID_WIDTH, default 1, request id width echoed in response.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-007 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-008 SHALL have port mem_in, mem_intf.in, valid/ready/read_enable/write_enable[DATA_WIDTH/8]/addr/data/id, request stream.
REQ-009 SHALL have port mem_out, mem_intf.out, valid/ready/data/id (read_enable=1, write_enable=0, addr=captured), response stream.

Function
REQ-010 Request accepted on any clk edge where mem_in.valid && mem_in.ready.
REQ-011 Accepted request SHALL write data bytes for each set write_enable bit at word addr.
REQ-012 Accepted request with read_enable=1 SHALL produce one response: data is the word content before that same request's write (read-before-write); id and addr are copied from the request.
REQ-013 Read latency: response SHALL be valid on mem_out in the cycle after acceptance when no earlier response is pending.
REQ-014 Counter outstanding (0..2) SHALL count accepted response-producing requests not yet handshaken on mem_out; +1 on accept, -1 on mem_out handshake, unchanged when both occur.
REQ-015 mem_in.ready SHALL be (outstanding < 2), a function of registered state only; no combinational path from mem_out.ready.
REQ-016 Back-to-back reads with mem_out.ready=1 SHALL sustain one accept and one response per cycle.
REQ-017 A response not taken in its first valid cycle SHALL move into a one-entry holding register; mem_out presents the holding entry first; responses leave strictly in acceptance order.
REQ-018 mem_out.valid and its payload SHALL stay stable until handshake.
REQ-019 Request with read_enable=0 and write_enable=0 SHALL be accepted and discarded without a response.
REQ-020 Address bits above WORD_BITS SHALL be ignored (aliasing wrap).

Reset
REQ-021 During reset: mem_in.ready=0, mem_out.valid=0, outstanding=0, holding register empty; RAM contents are unchanged.
REQ-022 Reset mid-operation SHALL drop all pending responses; the first request SHALL be accepted in the cycle after reset deasserts.

Configuration
REQ-023 Macro MEM_RAM_RESPONDER_WRITE_ACK_EN defined: write-only requests (read_enable=0, write_enable!=0) also produce a response with data = post-write word, counted by outstanding.
REQ-024 Macro undefined: write-only requests produce no response (REQ-012 only).

Structure
REQ-025 mem_pkg SHALL hold the response-entry typedef (valid, id, addr, data) shared with mem_split/mem_merge benches.
REQ-026 Byte-enable single-port RAM with registered read SHALL be a sub-module mem_ram_bank (parameters DATA_WIDTH, WORD_BITS).

Verification
REQ-027 Write addr 0x4 data 0xDEADBEEF we=4'hF, then read addr 0x4 id=1 -> response data 0xDEADBEEF, id 1, one cycle after read accept.
REQ-028 Write addr 0x8 we=4'h3 data 0x0000_1234 over 0xAAAA_AAAA -> later read returns 0xAAAA_1234.
REQ-029 Read+write same request addr 0xC (old 0x11, new 0x22) -> response 0x11; next read 0x22.
REQ-030 mem_out.ready=0, three reads issued -> two accepted, mem_in.ready=0; release ready -> responses in order, third accepted next cycle.
REQ-031 Continuous reads to 0..15 with ready=1 -> 16 responses in 17 cycles, ids preserved.
REQ-032 Reset asserted with outstanding=2 -> mem_out.valid=0 next cycle, no stale response after reset; with MEM_RAM_RESPONDER_WRITE_ACK_EN write-only to addr 0x10 data 0x5 -> response data 0x5.
